// File: rtl/mult_fu.sv
// Pipelined RV32M multiply unit: STAGES-deep shift-add pipeline feeding the CDB
// through a request/grant handshake, with stall on backpressure and squash flush.
module mult_fu #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned PR_IDX_W  = 6,
    parameter int unsigned ROB_IDX_W = 5,
    parameter int unsigned STAGES    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [1:0]           issue_func,
    input  logic [XLEN-1:0]      issue_opa,
    input  logic [XLEN-1:0]      issue_opb,
    input  logic [PR_IDX_W-1:0]  issue_pr_idx,
    input  logic [ROB_IDX_W-1:0] issue_rob_idx,
    input  logic                 squash,
    output logic                 busy,
    output logic                 cdb_req,
    input  logic                 cdb_gnt,
    output logic [XLEN-1:0]      cdb_value,
    output logic [PR_IDX_W-1:0]  cdb_pr_idx,
    output logic [ROB_IDX_W-1:0] cdb_rob_idx
);
    localparam int unsigned W2 = 2 * XLEN;
    localparam int unsigned CH = W2 / STAGES;

    typedef enum logic [1:0] {
        FN_MUL    = 2'b00,
        FN_MULH   = 2'b01,
        FN_MULHSU = 2'b10,
        FN_MULHU  = 2'b11
    } func_e;

    logic                 r_valid  [STAGES];
    func_e                r_func   [STAGES];
    logic [PR_IDX_W-1:0]  r_pr     [STAGES];
    logic [ROB_IDX_W-1:0] r_rob    [STAGES];
    logic [W2-1:0]        r_sum    [STAGES];
    logic [W2-1:0]        r_mcand  [STAGES];
    logic [W2-1:0]        r_mplier [STAGES];

    func_e         w_func;
    logic          w_sgn_a;
    logic          w_sgn_b;
    logic [W2-1:0] w_ext_a;
    logic [W2-1:0] w_ext_b;
    logic          w_advance;

    // Adds mcand * bits by shift-and-add, modulo 2^W2.
    function automatic logic [W2-1:0] add_chunk(input logic [W2-1:0] sum,
                                                 input logic [W2-1:0] mcand,
                                                 input logic [CH-1:0] bits);
        logic [W2-1:0] acc;
        acc = sum;
        for (int unsigned b = 0; b < CH; b++) begin
            if (bits[b]) acc = acc + (mcand << b);
        end
        return acc;
    endfunction

    always_comb begin
        w_func  = func_e'(issue_func);
        w_sgn_a = (w_func != FN_MULHU);
        w_sgn_b = (w_func == FN_MUL) || (w_func == FN_MULH);
        w_ext_a = {{XLEN{w_sgn_a & issue_opa[XLEN-1]}}, issue_opa};
        w_ext_b = {{XLEN{w_sgn_b & issue_opb[XLEN-1]}}, issue_opb};
    end

    assign w_advance = ~r_valid[STAGES-1] | cdb_gnt;
    assign busy      = ~w_advance;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_valid[k]  <= 1'b0;
                r_func[k]   <= FN_MUL;
                r_pr[k]     <= '0;
                r_rob[k]    <= '0;
                r_sum[k]    <= '0;
                r_mcand[k]  <= '0;
                r_mplier[k] <= '0;
            end
        end else if (squash) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
            end
        end else if (w_advance) begin
            for (int unsigned k = STAGES - 1; k > 0; k--) begin
                r_valid[k]  <= r_valid[k-1];
                r_func[k]   <= r_func[k-1];
                r_pr[k]     <= r_pr[k-1];
                r_rob[k]    <= r_rob[k-1];
                r_sum[k]    <= add_chunk(r_sum[k-1], r_mcand[k-1], r_mplier[k-1][CH-1:0]);
                r_mcand[k]  <= r_mcand[k-1] << CH;
                r_mplier[k] <= r_mplier[k-1] >> CH;
            end
            r_valid[0] <= issue_valid;
            // Bubbles enter with zeroed data so idle output fields read as zero.
            if (issue_valid) begin
                r_func[0]   <= w_func;
                r_pr[0]     <= issue_pr_idx;
                r_rob[0]    <= issue_rob_idx;
                r_sum[0]    <= add_chunk('0, w_ext_a, w_ext_b[CH-1:0]);
                r_mcand[0]  <= w_ext_a << CH;
                r_mplier[0] <= w_ext_b >> CH;
            end else begin
                r_func[0]   <= FN_MUL;
                r_pr[0]     <= '0;
                r_rob[0]    <= '0;
                r_sum[0]    <= '0;
                r_mcand[0]  <= '0;
                r_mplier[0] <= '0;
            end
        end
    end

    assign cdb_req     = r_valid[STAGES-1];
    assign cdb_pr_idx  = r_pr[STAGES-1];
    assign cdb_rob_idx = r_rob[STAGES-1];
    assign cdb_value   = (r_func[STAGES-1] == FN_MUL) ? r_sum[STAGES-1][XLEN-1:0]
                                                      : r_sum[STAGES-1][W2-1:XLEN];

endmodule

// File: tb/tb_mult_fu.sv
// Bench for mult_fu: directed scenarios plus randomized traffic scored against a
// timestamp queue model of in-order results.
module tb_mult_fu;
    localparam int unsigned STAGES = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [1:0]  issue_func;
    logic [31:0] issue_opa;
    logic [31:0] issue_opb;
    logic [5:0]  issue_pr_idx;
    logic [4:0]  issue_rob_idx;
    logic        squash;
    logic        busy;
    logic        cdb_req;
    logic        cdb_gnt;
    logic [31:0] cdb_value;
    logic [5:0]  cdb_pr_idx;
    logic [4:0]  cdb_rob_idx;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [31:0] val;
        logic [5:0]  pr;
        logic [4:0]  rob;
        int unsigned a;
    } op_t;

    op_t         q[$];
    int unsigned adv_cnt;
    logic        exp_req;
    logic        exp_busy;
    logic [31:0] exp_val;
    logic [5:0]  exp_pr;
    logic [4:0]  exp_rob;

    mult_fu #(.XLEN(32), .PR_IDX_W(6), .ROB_IDX_W(5), .STAGES(STAGES)) dut (
        .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_func(issue_func),
        .issue_opa(issue_opa), .issue_opb(issue_opb), .issue_pr_idx(issue_pr_idx),
        .issue_rob_idx(issue_rob_idx), .squash(squash), .busy(busy), .cdb_req(cdb_req),
        .cdb_gnt(cdb_gnt), .cdb_value(cdb_value), .cdb_pr_idx(cdb_pr_idx),
        .cdb_rob_idx(cdb_rob_idx)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        case (f)
            2'd0, 2'd1: p = 64'(longint'(signed'(a)) * longint'(signed'(b)));
            2'd2:       p = 64'(longint'(signed'(a)) * longint'({32'b0, b}));
            default:    p = {32'b0, a} * {32'b0, b};
        endcase
        return (f == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic model_req();
        return (q.size() > 0) && (adv_cnt - q[0].a >= STAGES);
    endfunction

    // Drive one cycle's inputs, then wait to mid-cycle and form model expectations.
    task automatic drive(input logic iv, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] pr, input logic [4:0] rob,
                         input logic gnt, input logic sq);
        issue_valid = iv; issue_func = f; issue_opa = a; issue_opb = b;
        issue_pr_idx = pr; issue_rob_idx = rob; cdb_gnt = gnt; squash = sq;
        @(negedge clock);
        exp_req  = model_req();
        exp_busy = exp_req && !gnt;
        exp_val  = exp_req ? q[0].val : '0;
        exp_pr   = exp_req ? q[0].pr  : '0;
        exp_rob  = exp_req ? q[0].rob : '0;
    endtask

    task automatic idle(input logic gnt);
        drive(1'b0, 2'd0, '0, '0, '0, '0, gnt, 1'b0);
    endtask

    task automatic tick();
        op_t t;
        @(posedge clock);
        if (reset === 1'b0 || squash) begin
            q.delete();
        end else if (!exp_busy) begin
            if (exp_req) void'(q.pop_front());
            if (issue_valid) begin
                t.val = ref_mul(issue_func, issue_opa, issue_opb);
                t.pr  = issue_pr_idx;
                t.rob = issue_rob_idx;
                t.a   = adv_cnt;
                q.push_back(t);
            end
            adv_cnt++;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'd3, $urandom, $urandom, 6'($urandom), 5'($urandom), 1'b1, 1'b0);
            tick();
        end
        reset = 1'b1;
        idle(1'b0);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (cdb_req !== 1'b0) begin n_errors++; $display("FAIL reset_req got=%b want=0", cdb_req); end
        n_checks++; if (cdb_value !== 32'h0) begin n_errors++; $display("FAIL reset_value got=%h want=0", cdb_value); end
        n_checks++; if (cdb_pr_idx !== 6'h0) begin n_errors++; $display("FAIL reset_pr got=%h want=0", cdb_pr_idx); end
        n_checks++; if (cdb_rob_idx !== 5'h0) begin n_errors++; $display("FAIL reset_rob got=%h want=0", cdb_rob_idx); end
        tick();
    endtask

    task automatic test_basic();
        drive(1'b1, 2'd0, 32'd3, 32'd7, 6'd5, 5'd2, 1'b1, 1'b0);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy got=%b want=0", busy); end
        tick();
        for (int c = 1; c <= 5; c++) begin
            idle(1'b1);
            n_checks++; if (cdb_req !== (c == 4)) begin n_errors++; $display("FAIL basic_req c=%0d got=%b want=%b", c, cdb_req, c == 4); end
            if (c == 4) begin
                n_checks++; if (cdb_value !== 32'd21) begin n_errors++; $display("FAIL basic_value got=%0d want=21", cdb_value); end
                n_checks++; if (cdb_pr_idx !== 6'd5) begin n_errors++; $display("FAIL basic_pr got=%0d want=5", cdb_pr_idx); end
                n_checks++; if (cdb_rob_idx !== 5'd2) begin n_errors++; $display("FAIL basic_rob got=%0d want=2", cdb_rob_idx); end
            end
            tick();
        end
    endtask

    task automatic test_funcs();
        logic [1:0]  fs[5] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd1};
        logic [31:0] as[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] bs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2, 32'h80000000};
        logic [31:0] es[5] = '{32'h1, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, fs[i], as[i], bs[i], 6'(i), 5'(i), 1'b1, 1'b0);
            tick();
            for (int c = 1; c < 4; c++) begin idle(1'b1); tick(); end
            idle(1'b1);
            n_checks++; if (cdb_req !== 1'b1 || cdb_value !== es[i]) begin n_errors++; $display("FAIL func%0d req=%b got=%h want=%h", i, cdb_req, cdb_value, es[i]); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e[4];
        logic [5:0]  p[4];
        logic [4:0]  r[4];
        logic [1:0]  f;
        logic [31:0] a, b;
        for (int c = 0; c <= 8; c++) begin
            if (c < 4) begin
                f = 2'($urandom); a = $urandom; b = $urandom; p[c] = 6'($urandom); r[c] = 5'($urandom);
                e[c] = ref_mul(f, a, b);
                drive(1'b1, f, a, b, p[c], r[c], 1'b1, 1'b0);
            end else begin
                idle(1'b1);
            end
            if (c <= 7) begin
                n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL b2b_busy c=%0d got=%b want=0", c, busy); end
            end
            n_checks++; if (cdb_req !== (c >= 4 && c <= 7)) begin n_errors++; $display("FAIL b2b_req c=%0d got=%b", c, cdb_req); end
            if (c >= 4 && c <= 7) begin
                n_checks++; if ({cdb_value, cdb_pr_idx, cdb_rob_idx} !== {e[c-4], p[c-4], r[c-4]}) begin
                    n_errors++; $display("FAIL b2b_result c=%0d got=%h/%0d/%0d want=%h/%0d/%0d", c, cdb_value, cdb_pr_idx, cdb_rob_idx, e[c-4], p[c-4], r[c-4]);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e[4];
        logic [5:0]  p[4];
        logic [4:0]  r[4];
        logic [1:0]  f;
        logic [31:0] a, b;
        int          idx;
        logic        want_req, want_busy;
        for (int c = 0; c <= 11; c++) begin
            if (c < 4) begin
                f = 2'($urandom); a = $urandom; b = $urandom; p[c] = 6'($urandom); r[c] = 5'($urandom);
                e[c] = ref_mul(f, a, b);
                drive(1'b1, f, a, b, p[c], r[c], 1'b1, 1'b0);
            end else begin
                idle(!(c >= 4 && c <= 6));
            end
            want_req  = (c >= 4 && c <= 10);
            want_busy = (c >= 4 && c <= 6);
            idx       = (c <= 7) ? 0 : c - 7;
            n_checks++; if (busy !== want_busy) begin n_errors++; $display("FAIL bp_busy c=%0d got=%b want=%b", c, busy, want_busy); end
            n_checks++; if (cdb_req !== want_req) begin n_errors++; $display("FAIL bp_req c=%0d got=%b want=%b", c, cdb_req, want_req); end
            if (want_req) begin
                n_checks++; if ({cdb_value, cdb_pr_idx, cdb_rob_idx} !== {e[idx], p[idx], r[idx]}) begin
                    n_errors++; $display("FAIL bp_result c=%0d got=%h/%0d/%0d want=%h/%0d/%0d", c, cdb_value, cdb_pr_idx, cdb_rob_idx, e[idx], p[idx], r[idx]);
                end
            end
            tick();
        end
    endtask

    task automatic test_squash();
        logic [31:0] e3;
        logic [4:0]  r3;
        for (int c = 0; c <= 8; c++) begin
            if (c < 3) drive(1'b1, 2'd0, $urandom, $urandom, 6'($urandom), 5'($urandom), 1'b1, c == 2);
            else idle(1'b1);
            n_checks++; if (cdb_req !== 1'b0) begin n_errors++; $display("FAIL squash_req c=%0d got=%b want=0", c, cdb_req); end
            tick();
        end
        e3 = ref_mul(2'd3, 32'd123456, 32'd654321);
        r3 = 5'd17;
        for (int c = 0; c <= 8; c++) begin
            if (c < 3) drive(1'b1, 2'd0, $urandom, $urandom, 6'($urandom), 5'($urandom), 1'b1, c == 2);
            else if (c == 3) drive(1'b1, 2'd3, 32'd123456, 32'd654321, 6'd9, r3, 1'b1, 1'b0);
            else idle(1'b1);
            n_checks++; if (cdb_req !== (c == 7)) begin n_errors++; $display("FAIL squash_reissue_req c=%0d got=%b want=%b", c, cdb_req, c == 7); end
            if (c == 7) begin
                n_checks++; if (cdb_value !== e3 || cdb_rob_idx !== r3) begin n_errors++; $display("FAIL squash_reissue_result got=%h/%0d want=%h/%0d", cdb_value, cdb_rob_idx, e3, r3); end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c <= 8; c++) begin
            reset = (c == 2) ? 1'b0 : 1'b1;
            if (c <= 2) drive(1'b1, 2'd1, $urandom | 32'h1, $urandom | 32'h1, 6'($urandom), 5'($urandom), 1'b1, 1'b0);
            else idle(1'b1);
            if (c >= 3) begin
                n_checks++; if ({busy, cdb_req} !== 2'b00) begin n_errors++; $display("FAIL rstmid_ctl c=%0d got busy=%b req=%b want 0/0", c, busy, cdb_req); end
                n_checks++; if ({cdb_value, cdb_pr_idx, cdb_rob_idx} !== 43'h0) begin n_errors++; $display("FAIL rstmid_data c=%0d got=%h/%0d/%0d want=0", c, cdb_value, cdb_pr_idx, cdb_rob_idx); end
            end
            tick();
        end
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic gnt, iv, sq;
        for (int c = 0; c < 600; c++) begin
            gnt = ($urandom_range(0, 9) < 7);
            iv  = !(model_req() && !gnt) && ($urandom_range(0, 9) < 6);
            sq  = ($urandom_range(0, 39) == 0);
            drive(iv, 2'($urandom), $urandom, $urandom, 6'($urandom), 5'($urandom), gnt, sq);
            n_checks++; if (cdb_req !== exp_req) begin n_errors++; $display("FAIL rand_req c=%0d got=%b want=%b", c, cdb_req, exp_req); end
            n_checks++; if (busy !== exp_busy) begin n_errors++; $display("FAIL rand_busy c=%0d got=%b want=%b", c, busy, exp_busy); end
            if (exp_req) begin
                n_checks++; if ({cdb_value, cdb_pr_idx, cdb_rob_idx} !== {exp_val, exp_pr, exp_rob}) begin
                    n_errors++; $display("FAIL rand_result c=%0d got=%h/%0d/%0d want=%h/%0d/%0d", c, cdb_value, cdb_pr_idx, cdb_rob_idx, exp_val, exp_pr, exp_rob);
                end
            end
            tick();
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0; adv_cnt = 0;
        reset = 1'b0; issue_valid = 1'b0; issue_func = '0; issue_opa = '0; issue_opb = '0;
        issue_pr_idx = '0; issue_rob_idx = '0; squash = 1'b0; cdb_gnt = 1'b0;
        @(posedge clock); #1;
        test_reset();
        test_basic();
        test_funcs();
        test_back_to_back();
        test_backpressure();
        test_squash();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mult_fu.md
# mult_fu

Pipelined integer multiply functional unit. It sits on the far side of the reservation-station issue interface: it accepts operations that the RS issues with fu_sel MULT_1/MULT_2, and it reports its busy status back to the RS (the mult bit of the FU status the RS consumes). Each result, with its physical-register and ROB tags, is presented to the CDB arbiter under a request/grant handshake. The unit computes RV32M MUL/MULH/MULHSU/MULHU in a STAGES-deep shift-add pipeline, stalls under CDB backpressure and flushes on squash.

## Interface
- XLEN, 32, operand/result width
- PR_IDX_W, 6, physical register tag width
- ROB_IDX_W, 5, ROB tag width
- STAGES, 4, pipeline depth; must divide 2*XLEN
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-low (0 = reset), sampled on posedge clock
- issue_valid  in  1  RS issues an op this cycle
- issue_func  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- issue_opa  in  XLEN  rs1 value
- issue_opb  in  XLEN  rs2 value
- issue_pr_idx  in  PR_IDX_W  destination physical register
- issue_rob_idx  in  ROB_IDX_W  ROB entry
- squash  in  1  branch-mispredict flush
- busy  out  1  to RS: unit cannot accept an issue this cycle
- cdb_req  out  1  result valid, requesting CDB
- cdb_gnt  in  1  arbiter grant; depends only on requests, never on busy
- cdb_value  out  XLEN  result
- cdb_pr_idx  out  PR_IDX_W  result tag
- cdb_rob_idx  out  ROB_IDX_W  result ROB tag

## Operation
- Stage registers S0..S(STAGES-1). Each holds valid, func, pr_idx, rob_idx, a 2*XLEN partial sum, the 2*XLEN multiplicand (pre-shifted) and the remaining multiplier bits. S(STAGES-1) is the output register.
- Operand extension to 2*XLEN at issue: MUL/MULH sign-extend both operands. MULHSU sign-extends opa and zero-extends opb. MULHU zero-extends both.
- CH = 2*XLEN/STAGES multiplier bits are consumed per transfer. Capture into S0 adds chunk 0 (combinationally from the extended inputs); each S(k)->S(k+1) transfer adds chunk k+1. All arithmetic is modulo 2^(2*XLEN).
- Result: MUL = product[XLEN-1:0]; others = product[2*XLEN-1:XLEN].
- advance = ~S(STAGES-1).valid | cdb_gnt. When advance=1, every stage shifts forward; bubbles shift as valid=0. When advance=0, all stages hold.
- busy = ~advance (combinational). Issue is accepted iff issue_valid & ~busy. An issue_valid presented while busy is dropped; the RS must not issue while busy, and the bench flags it.
- cdb_req = S(STAGES-1).valid. cdb_value and the cdb tags come from S(STAGES-1) and hold stable while cdb_req=1 and cdb_gnt=0.
- squash: at the next edge all valids clear. Squash takes priority over the issue and the grant in the same cycle; an issue in the squash cycle is dropped. Data fields may remain; only valid is cleared.
- Results leave in issue order. There is no reordering and no bypass.

## Timing
- Reset (reset=0 at an edge): all valids and data cleared. Next cycle: busy=0, cdb_req=0, cdb_value=0, cdb_pr_idx=0, cdb_rob_idx=0. Reset overrides squash, issue and grant, including mid-operation.
- Latency: an op issued in cycle T (no stall) has cdb_req=1 in cycle T+STAGES (T+4 by default).
- Throughput: one op per cycle when cdb_gnt=1 is held.
- Handshake: the result is consumed at the edge where cdb_req & cdb_gnt. cdb_gnt while cdb_req=0 is ignored.
- Stall: each cycle of cdb_req & ~cdb_gnt delays every in-flight op by one cycle and holds busy=1 for that cycle.
- Empty pipeline with cdb_gnt=0: busy=0, and issue is accepted.
- Full pipeline with output granted: the issue is accepted in the same cycle (advance=1).

## Test plan
- Basic MUL: issue MUL 3*7, pr=5, rob=2 at cycle 0, gnt=1 -> cdb_req=1 only in cycle 4, value=21, pr=5, rob=2.
- All funcs: check each of the following.
  - MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001
  - MULH same operands -> 0x00000000
  - MULHU same operands -> 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF
  - MULH 0x80000000*0x80000000 -> 0x40000000
- Back-to-back: issue 4 ops in cycles 0-3, gnt=1 -> results in cycles 4-7 in order, busy=0 throughout.
- Backpressure: same stream with gnt=0 in cycles 4-6.
  - busy=1 in cycles 4-6; cycle-4 value and tags held stable.
  - Results in cycles 4(held)-7, 8, 9, 10; no loss or duplication.
- Squash: issue in cycles 0-2, squash in cycle 2 -> cdb_req stays 0 through cycle 8. An issue in cycle 3 returns in cycle 7.
- Reset mid-flight: reset=0 in cycle 2 with 2 ops in flight -> all outputs 0 from cycle 3, and no cdb_req afterwards.
